// File: rtl/alu_regfile.sv
// alu_regfile
//   Register file and flags register sitting directly in front of the ALU.
//   Two registered read ports feed the ALU A/B operands. The single write
//   port takes the ALU result back. A flags register captures the ALU flags
//   and returns the stored carry as the ALU carry-in.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset (clears storage and outputs)
//   ra_addr    in   read port A address
//   rb_addr    in   read port B address
//   wr_en      in   write enable
//   wr_addr    in   write address
//   wr_data    in   write data (normally ALU C)
//   flags_we   in   load flags_in into the flags register
//   flags_in   in   ALU flags
//   a_out      out  registered read data, port A (1-cycle latency)
//   b_out      out  registered read data, port B (1-cycle latency)
//   flags_out  out  flags register contents
//   cin_out    out  flags_out[CARRY_B], combinational
//
// Handshake: none. Every input is sampled on every rising edge; there is no
// valid/ready pairing and no back-pressure.
//
// There is no state machine in this block.
module alu_regfile #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int FLAGS_W = 5,
    parameter int CARRY_B = 3,
    parameter int ZERO_R0 = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  ra_addr,
    input  logic [ADDR_W-1:0]  rb_addr,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               flags_we,
    input  logic [FLAGS_W-1:0] flags_in,
    output logic [DATA_W-1:0]  a_out,
    output logic [DATA_W-1:0]  b_out,
    output logic [FLAGS_W-1:0] flags_out,
    output logic               cin_out
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [DATA_W-1:0]  mem_d [DEPTH];
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [FLAGS_W-1:0] flags_q, flags_d;

    // A write to r0 is swallowed when r0 is hard-wired to zero.
    logic wr_eff;
    logic r0_fixed;

    // Stored contents of an address; r0 reads 0 regardless of history
    // when it is hard-wired.
    function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] addr);
        if (r0_fixed && addr == '0) begin
            return '0;
        end
        return mem_q[addr];
    endfunction

    always_comb begin
        r0_fixed = (ZERO_R0 != 0);
        wr_eff   = wr_en && !(r0_fixed && wr_addr == '0);

        // Storage update.
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_eff) begin
            mem_d[wr_addr] = wr_data;
        end

        // Read ports. When the same edge writes the address being read, the
        // new data is forwarded so the ALU never sees a stale operand. A
        // suppressed r0 write does not forward, so r0 still reads zero.
        a_d = rd_val(ra_addr);
        b_d = rd_val(rb_addr);
        if (wr_eff && wr_addr == ra_addr) begin
            a_d = wr_data;
        end
        if (wr_eff && wr_addr == rb_addr) begin
            b_d = wr_data;
        end

        // Flags load, independent of the register write.
        flags_d = flags_q;
        if (flags_we) begin
            flags_d = flags_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            a_q     <= '0;
            b_q     <= '0;
            flags_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            a_q     <= a_d;
            b_q     <= b_d;
            flags_q <= flags_d;
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign flags_out = flags_q;
    assign cin_out   = flags_q[CARRY_B];

endmodule
